instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the RV32 core, sitting directly upstream of the control unit. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. It buffers returned instructions with their PCs in a small FIFO and presents them to decode with pre-split opcode/func3/func7 fields. Branch redirects flush all in-flight and buffered work.

## Interface

- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC after reset
- DEPTH, 4, instruction buffer entries and maximum requests in flight; power of two, at least 2

- clk  in  1  clock; everything changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  XLEN  fetch address; always equal to pc
- imem_rsp_valid  in  1  response beat; one per accepted request, in order, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump redirect, 1-cycle pulse
- redirect_pc  in  XLEN  redirect target
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode consumes the head
- inst_data  out  32  head instruction
- inst_pc  out  XLEN  head PC
- inst_opcode  out  7  inst_data[6:0]
- inst_func3  out  3  inst_data[14:12]
- inst_func7  out  7  inst_data[31:25]

## Operation

- State: pc, outstanding (0..DEPTH), drop (0..DEPTH), request-PC queue (DEPTH), instruction FIFO of {pc, data} (DEPTH), and a 2-state FSM with states FETCH and FLUSH.
- credit = (outstanding + fifo_count < DEPTH), using registered values only.
- imem_req_valid = (state==FETCH) && credit && !redirect_valid.
- Request accept (valid && ready): the address is pushed to the request-PC queue, outstanding increments, and pc <= pc + 4 (modulo 2^XLEN; wraps to 0).
- Response in FETCH: the request-PC queue is popped, {pc, data} is pushed to the FIFO, and outstanding decrements.
- Response in FLUSH: the queue is popped, the data is discarded, and both drop and outstanding decrement.
- Pop (inst_valid && inst_ready): the head is removed.
- Redirect: pc <= {redirect_pc[XLEN-1:2], 2'b00}; the FIFO is emptied; drop <= outstanding minus 1 if a response arrives that same cycle; state becomes FLUSH if that drop value is >0, otherwise FETCH.
- A response in the redirect cycle is discarded.
- A pop in the redirect cycle completes normally; decode owns that beat.
- FLUSH to FETCH transition: when drop reaches 0, on the same edge as the last discarded response.
- A redirect received during FLUSH updates pc; drop is recomputed by the same rule.
- No new requests are issued in FLUSH.
- imem_req_ready low holds imem_req_addr/pc stable; there is no request timeout.
- The FIFO never overflows by construction of credit. A response with outstanding==0 is a protocol violation and is ignored.

## Timing

- Reset (async assert, sync release): pc=RESET_PC, state=FETCH, outstanding=drop=0, FIFO empty, inst_valid=0, imem_req_valid=0 while rst_n low.
- inst_* outputs are 0 when the FIFO is empty.
- First request is issued in the first cycle after rst_n deasserts, with addr=RESET_PC.
- Response at cycle N produces inst_valid at N+1 (registered FIFO, no bypass).
- Throughput with 1-cycle memory latency and DEPTH=4: one instruction per cycle sustained.
- A redirect at cycle R makes imem_req_valid low at R. If no responses are outstanding, the request to redirect_pc is issued at R+1.
- The first inst_valid after a redirect carries inst_pc = redirect target.
- Reset asserted mid-operation clears everything immediately. In-flight memory responses after reset are the memory's responsibility and are ignored, since outstanding=0.

## Test plan

- Reset, then imem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests to 0,4,8,12… on consecutive cycles; inst_pc 0,4,8… with inst_valid continuous from cycle 2; opcode/func3/func7 match the word fields (e.g. 0x00A30333 gives 0x33/0/0).
- inst_ready=0 for 20 cycles -> at most 4 requests accepted, FIFO holds PCs 0,4,8,12; releasing inst_ready delivers all four in order with no loss or duplication.
- Memory latency 3, two requests outstanding, redirect to 0x100 -> the two responses are dropped; next request to 0x100 follows the last drop; first delivered inst_pc=0x100.
- Redirect to 0x203 with zero outstanding -> request at the next cycle to 0x200.
- Redirect coinciding with a response and a pop -> the pop completes, the response is discarded, and the FIFO is empty the next cycle.
- imem_req_ready low 5 cycles -> imem_req_addr is stable; rst_n pulsed low mid-stream -> all outputs go to their reset values the same cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch: owns the PC, issues word fetches with bounded in-flight
// requests, buffers {pc, data} in a FIFO and flushes on branch redirects.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      inst_opcode,
  output logic [2:0]      inst_func3,
  output logic [6:0]      inst_func7
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding, drop, drop_next, fifo_count;

  logic [XLEN-1:0] rq_mem [DEPTH];
  logic [AW-1:0]   rq_wr, rq_rd;
  logic [XLEN-1:0] f_pc   [DEPTH];
  logic [31:0]     f_data [DEPTH];
  logic [AW-1:0]   f_wr, f_rd;

  logic credit, req_fire, rsp, keep, pop;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign credit         = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  // Gated by rst_n so no request is visible while reset is held.
  assign imem_req_valid = rst_n && (state == FETCH) && credit && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp            = imem_rsp_valid && (outstanding != '0);
  assign keep           = rsp && (state == FETCH) && !redirect_valid;
  assign inst_valid     = (fifo_count != '0);
  assign pop            = inst_valid && inst_ready;

  assign inst_data   = inst_valid ? f_data[f_rd] : '0;
  assign inst_pc     = inst_valid ? f_pc[f_rd]   : '0;
  assign inst_opcode = inst_data[6:0];
  assign inst_func3  = inst_data[14:12];
  assign inst_func7  = inst_data[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      drop  <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (redirect_valid) begin
      drop_next  = outstanding - CW'(rsp);
      state_next = (drop_next != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && rsp) begin
      drop_next = drop - CW'(1);
      if (drop_next == '0) state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      rq_wr       <= '0;
      rq_rd       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      fifo_count  <= '0;
    end else begin
      if (redirect_valid)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)   pc <= pc + XLEN'(4);
      if (req_fire) rq_wr <= rq_wr + AW'(1);
      if (rsp)      rq_rd <= rq_rd + AW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
      if (redirect_valid) begin
        f_wr       <= '0;
        f_rd       <= '0;
        fifo_count <= '0;
      end else begin
        if (keep) f_wr <= f_wr + AW'(1);
        if (pop)  f_rd <= f_rd + AW'(1);
        fifo_count <= fifo_count + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) rq_mem[rq_wr] <= imem_req_addr;
    if (keep) begin
      f_pc[f_wr]   <= rq_mem[rq_rd];
      f_data[f_wr] <= imem_rsp_data;
    end
  end

endmodule
